// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: owns the fetch PC, reads the ICache, predicts
// branch/JAL targets statically and buffers fetched instructions in a FIFO.
module fetch_queue_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [XLEN-1:0]         ic_addr,
  output logic                    ic_valid,
  input  logic                    ic_stall,
  input  logic [31:0]             ic_inst,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  input  logic                    id_ready,
  output logic                    id_valid,
  output logic [XLEN-1:0]         id_pc,
  output logic [31:0]             id_inst,
  output logic                    id_pred_taken,
  output logic [XLEN-1:0]         id_pred_pc,
  output logic [$clog2(QDEPTH):0] q_count
);

  localparam int unsigned PW        = $clog2(QDEPTH);
  localparam int unsigned CW        = PW + 1;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            pred_taken;
    logic [XLEN-1:0] pred_pc;
  } entry_t;

  entry_t          mem [QDEPTH];
  logic [XLEN-1:0] pc_q;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            full;
  logic            deq;
  logic            enq;
  logic [XLEN-1:0] j_off;
  logic [XLEN-1:0] b_off;
  entry_t          new_entry;

  assign full     = (count == CW'(QDEPTH));
  assign id_valid = (count != '0);
  assign deq      = id_valid & id_ready;
  assign ic_valid = rst & ~redirect_valid & (~full | deq);
  assign enq      = ic_valid & ~ic_stall;
  assign ic_addr  = pc_q;
  assign q_count  = count;

  // Static prediction: JAL always taken, backward branches taken, rest fall through
  always_comb begin
    j_off = {{(XLEN-21){ic_inst[31]}}, ic_inst[31], ic_inst[19:12], ic_inst[20],
             ic_inst[30:21], 1'b0};
    b_off = {{(XLEN-13){ic_inst[31]}}, ic_inst[31], ic_inst[7], ic_inst[30:25],
             ic_inst[11:8], 1'b0};
    new_entry.pc         = pc_q;
    new_entry.inst       = ic_inst;
    new_entry.pred_taken = 1'b0;
    new_entry.pred_pc    = pc_q + XLEN'(4);
    case (ic_inst[6:0])
      OP_JAL: begin
        new_entry.pred_taken = 1'b1;
        new_entry.pred_pc    = pc_q + j_off;
      end
      OP_BRANCH: begin
        if (ic_inst[31]) begin
          new_entry.pred_taken = 1'b1;
          new_entry.pred_pc    = pc_q + b_off;
        end
      end
      default: ;
    endcase
  end

  // PC, pointers and occupancy; reset beats redirect, redirect beats enq/deq
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc_q   <= redirect_pc & ~XLEN'(3);
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PW'(1);
        pc_q   <= new_entry.pred_pc;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // Queue storage; slot at wr_ptr is free whenever enq is asserted
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Head view; empty queue presents a NOP with zeroed metadata
  always_comb begin
    id_pc         = '0;
    id_inst       = NOP;
    id_pred_taken = 1'b0;
    id_pred_pc    = '0;
    if (id_valid) begin
      id_pc         = mem[rd_ptr].pc;
      id_inst       = mem[rd_ptr].inst;
      id_pred_taken = mem[rd_ptr].pred_taken;
      id_pred_pc    = mem[rd_ptr].pred_pc;
    end
  end

endmodule
